fade_apply: RTL and testbench
=============================

// Module: fade_apply
// PURPOSE
//  Consumer of the fader coefficient stream. Captures the per-channel complex fading
//  coefficients Zc into a ping-pong bank, one full burst of NCHAN per t_index.
//  Multiplies an incoming channel-tagged complex sample stream by the active coefficient,
//  giving y = Zc * x. Sits directly downstream of fader, ahead of the channel combiner.
// PARAMETERS
//  NCHAN   32  channels per coefficient burst
//  CHAN_W  5   width of channel index, clog2(NCHAN)
//  DW      16  sample and coefficient width, signed two's complement
//  FRAC    15  fractional bits of Zc (Q1.15)
// PORTS
//  clk        in   1       system clock
//  reset      in   1       synchronous, active-high reset
//  coef_dv    in   1       coefficient valid (driven by fader dv_out)
//  coef_chan  in   CHAN_W  coefficient channel (fader chan_out)
//  coef_real  in   DW      Zc real part (fader Zc_real)
//  coef_imag  in   DW      Zc imaginary part (fader Zc_imag)
//  s_valid    in   1       input sample valid
//  s_chan     in   CHAN_W  input sample channel
//  s_real     in   DW      input sample real part
//  s_imag     in   DW      input sample imaginary part
//  m_valid    out  1       output sample valid
//  m_chan     out  CHAN_W  output channel (s_chan, delayed)
//  m_real     out  DW      faded sample, real part
//  m_imag     out  DW      faded sample, imaginary part
//  bank_valid out  1       at least one complete bank has been committed
//  coef_err   out  1       one-cycle pulse: burst ended incomplete, swap suppressed
//  frame_cnt  out  25      count of committed banks (wraps at 2^25)
// BEHAVIOUR
//  Reset: m_valid, bank_valid, coef_err = 0; m_chan, m_real, m_imag, frame_cnt = 0;
//   written-bitmap cleared; write bank = 0, read bank = 1. Bank RAM contents are not reset.
//  Coef capture: on coef_dv, write {real,imag} to wbank[coef_chan] and set bitmap[coef_chan].
//   - A duplicate channel in one burst overwrites the entry; its bitmap bit stays set.
//  Commit: on coef_dv with coef_chan==NCHAN-1, check the bitmap including the current write.
//   - Bitmap full: next cycle the banks swap, bank_valid=1, frame_cnt++, bitmap clears.
//   - Bitmap not full: next cycle coef_err=1 for 1 cycle, bitmap clears, no swap, and
//     frame_cnt/bank_valid are unchanged.
//  Samples never stall: there is no backpressure. Every s_valid produces m_valid exactly
//   3 cycles later (L=3), with m_chan = s_chan. Stages: S1 rbank read; S2 4 products;
//   S3 sum, round, saturate.
//  A swap takes effect for samples whose s_valid is in the cycle after the swap cycle.
//   In-flight samples keep the coefficients read at S1.
//  Simultaneous coef write and sample read use different banks, so there is no conflict.
//  Arithmetic: pr = xr*cr - xi*ci; pi = xr*ci + xi*cr, in 2*DW+1 bits.
//   - Round half-up: add 2^(FRAC-1), then arithmetic shift right by FRAC.
//   - Saturate to [-2^(DW-1), 2^(DW-1)-1].
//  While bank_valid=0 the coefficient is forced to 0: m_valid still fires, with y=(0,0).
//  m_real, m_imag and m_chan hold their last value while m_valid=0.
//  Reset mid-operation: pipeline is flushed (no m_valid after reset), bank_valid drops to 0,
//   and the partial burst is discarded.
// TESTING
//  T1 first burst chans 0..31, Zc=(16384,0), then x=(16384,0) on ch 5
//     -> 3 cycles later m_valid, m_chan=5, y=(8192,0); bank_valid=1; frame_cnt=1.
//  T2 Zc[7]=(0,16384), x=(0,16384) on ch 7 -> y=(-8192,0);
//     Zc[7]=(23170,23170), x=(10000,0) -> y=(7071,7071).
//  T3 Zc=(-32768,0), x=(-32768,0) -> y=(32767,0) saturated;
//     Zc=(-32768,0), x=(32767,0) -> y=(-32767,0).
//  T4 back-to-back bursts every 300 cycles, Zc=ch*256, with samples on ch 3 every cycle
//     -> output switches to the new value exactly for s_valid one cycle after the swap.
//  T5 burst missing ch 12, ending at ch 31 -> coef_err pulses 1 cycle, no swap,
//     frame_cnt unchanged, old coefficients still applied.
//  T6 before any burst, x=(1000,1000) -> y=(0,0) with m_valid.
//     Assert reset mid-burst with 2 samples in flight -> no m_valid after reset,
//     bank_valid=0, frame_cnt=0.

Source files
------------

// File: rtl/fade_apply_if.sv
// fade_apply_if: groups the coefficient stream, the sample stream in/out and the
// bank status of fade_apply into one bundle.
//   coef_dv/coef_chan/coef_real/coef_imag : coefficient burst from the fader
//   s_valid/s_chan/s_real/s_imag          : channel-tagged complex input samples
//   m_valid/m_chan/m_real/m_imag          : faded output samples
//   bank_valid/coef_err/frame_cnt         : bank commit status
// slave  = fade_apply side, master = upstream/downstream driver side.
interface fade_apply_if #(
    parameter int CHAN_W = 5,
    parameter int DW     = 16
);
    logic                     coef_dv;
    logic [CHAN_W-1:0]        coef_chan;
    logic signed [DW-1:0]     coef_real;
    logic signed [DW-1:0]     coef_imag;
    logic                     s_valid;
    logic [CHAN_W-1:0]        s_chan;
    logic signed [DW-1:0]     s_real;
    logic signed [DW-1:0]     s_imag;
    logic                     m_valid;
    logic [CHAN_W-1:0]        m_chan;
    logic signed [DW-1:0]     m_real;
    logic signed [DW-1:0]     m_imag;
    logic                     bank_valid;
    logic                     coef_err;
    logic [24:0]              frame_cnt;

    modport slave (
        input  coef_dv, coef_chan, coef_real, coef_imag,
        input  s_valid, s_chan, s_real, s_imag,
        output m_valid, m_chan, m_real, m_imag,
        output bank_valid, coef_err, frame_cnt
    );

    modport master (
        output coef_dv, coef_chan, coef_real, coef_imag,
        output s_valid, s_chan, s_real, s_imag,
        input  m_valid, m_chan, m_real, m_imag,
        input  bank_valid, coef_err, frame_cnt
    );
endinterface

// File: rtl/fade_apply.sv
// fade_apply: captures per-channel complex fading coefficients into a ping-pong bank
// and multiplies the channel-tagged complex sample stream by the active coefficient,
// y = Zc * x (Zc in Q1.15), with half-up rounding and saturation.
// Ports:
//   clk   : system clock
//   reset : synchronous, active-high reset
//   bus   : fade_apply_if.slave (coefficient in, samples in/out, bank status)
// Latency is fixed at 3 cycles from s_valid to m_valid, with no backpressure.
module fade_apply #(
    parameter int NCHAN  = 32,
    parameter int CHAN_W = 5,
    parameter int DW     = 16,
    parameter int FRAC   = 15
) (
    input  logic          clk,
    input  logic          reset,
    fade_apply_if.slave   bus
);
    localparam int PW = 2 * DW;
    localparam int SW = 2 * DW + 1;
    localparam logic signed [SW-1:0] RND  = SW'(1) <<< (FRAC - 1);
    localparam logic signed [SW-1:0] MAXV = SW'((2 ** (DW - 1)) - 1);
    localparam logic signed [SW-1:0] MINV = SW'(-(2 ** (DW - 1)));

    // Both banks live in one array, addressed by {bank, channel}.
    logic [2*DW-1:0]   mem [0:2*NCHAN-1];

    logic [NCHAN-1:0]  bitmap;
    logic [NCHAN-1:0]  bitmap_nxt;
    logic              last_coef;
    logic              burst_full;
    logic              wsel;
    logic              rsel;
    logic              rd_ok;
    logic              swap_pend;

    logic                     v1, v2;
    logic [CHAN_W-1:0]        chan1, chan2;
    logic signed [DW-1:0]     xr1, xi1, cr1, ci1;
    logic signed [PW-1:0]     p_rr, p_ii, p_ri, p_ir;

    function automatic logic signed [DW-1:0] rnd_sat(input logic signed [SW-1:0] v);
        logic signed [SW-1:0] r;
        r = (v + RND) >>> FRAC;
        if (r > MAXV)
            return DW'(MAXV);
        else if (r < MINV)
            return DW'(MINV);
        else
            return DW'(r);
    endfunction

    always_comb begin
        bitmap_nxt = bitmap | (NCHAN'(1) << bus.coef_chan);
        last_coef  = bus.coef_dv && (bus.coef_chan == CHAN_W'(NCHAN - 1));
        burst_full = &bitmap_nxt;
    end

    always_ff @(posedge clk) begin
        if (bus.coef_dv)
            mem[{wsel, bus.coef_chan}] <= {bus.coef_real, bus.coef_imag};
    end

    // The write side flips in the commit cycle so the next burst can start at once;
    // the read side flips one cycle later, so samples arriving in the cycle right
    // after the commit still use the old bank.
    always_ff @(posedge clk) begin
        if (reset) begin
            bitmap         <= '0;
            wsel           <= 1'b0;
            rsel           <= 1'b1;
            rd_ok          <= 1'b0;
            swap_pend      <= 1'b0;
            bus.bank_valid <= 1'b0;
            bus.coef_err   <= 1'b0;
            bus.frame_cnt  <= '0;
        end else begin
            coef_err_clear: begin
                bus.coef_err <= 1'b0;
                swap_pend    <= 1'b0;
            end
            if (swap_pend) begin
                rsel  <= ~rsel;
                rd_ok <= 1'b1;
            end
            if (bus.coef_dv) begin
                if (last_coef) begin
                    bitmap <= '0;
                    if (burst_full) begin
                        wsel           <= ~wsel;
                        swap_pend      <= 1'b1;
                        bus.bank_valid <= 1'b1;
                        bus.frame_cnt  <= bus.frame_cnt + 25'd1;
                    end else begin
                        bus.coef_err   <= 1'b1;
                    end
                end else begin
                    bitmap <= bitmap_nxt;
                end
            end
        end
    end

    // S1: coefficient read; forced to zero until a bank has been committed.
    always_ff @(posedge clk) begin
        if (reset)
            v1 <= 1'b0;
        else
            v1 <= bus.s_valid;
        chan1 <= bus.s_chan;
        xr1   <= bus.s_real;
        xi1   <= bus.s_imag;
        if (rd_ok)
            {cr1, ci1} <= mem[{rsel, bus.s_chan}];
        else
            {cr1, ci1} <= '0;
    end

    // S2: four partial products.
    always_ff @(posedge clk) begin
        if (reset)
            v2 <= 1'b0;
        else
            v2 <= v1;
        chan2 <= chan1;
        p_rr  <= PW'(xr1) * PW'(cr1);
        p_ii  <= PW'(xi1) * PW'(ci1);
        p_ri  <= PW'(xr1) * PW'(ci1);
        p_ir  <= PW'(xi1) * PW'(cr1);
    end

    // S3: sum, round, saturate; outputs hold while no sample is present.
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.m_valid <= 1'b0;
            bus.m_chan  <= '0;
            bus.m_real  <= '0;
            bus.m_imag  <= '0;
        end else begin
            bus.m_valid <= v2;
            if (v2) begin
                bus.m_chan <= chan2;
                bus.m_real <= rnd_sat(SW'(p_rr) - SW'(p_ii));
                bus.m_imag <= rnd_sat(SW'(p_ri) + SW'(p_ir));
            end
        end
    end
endmodule

// File: tb/tb_fade_apply.sv
// Directed bench for fade_apply: coefficient bursts, complex multiply with rounding
// and saturation, swap timing, incomplete bursts and mid-operation reset.
module tb_fade_apply;
    logic clk;
    logic reset;
    int   tests;
    int   fails;
    int   cr_tab [32];
    int   ci_tab [32];

    fade_apply_if #(.CHAN_W(5), .DW(16)) bus ();

    fade_apply #(.NCHAN(32), .CHAN_W(5), .DW(16), .FRAC(15)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic signed [31:0] obs, input int exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Drive one sample, check nothing appears early, then check the result 3 cycles
    // later and that the outputs hold once m_valid drops.
    task automatic send_sample(input string tag, input int ch, input int xr, input int xi,
                               input int er, input int ei);
        bus.s_valid = 1'b1;
        bus.s_chan  = 5'(ch);
        bus.s_real  = 16'(xr);
        bus.s_imag  = 16'(xi);
        tick();
        bus.s_valid = 1'b0;
        tick();
        chk({tag, "_early"}, bus.m_valid, 0);
        tick();
        chk({tag, "_valid"}, bus.m_valid, 1);
        chk({tag, "_chan"},  bus.m_chan, ch);
        chk({tag, "_real"},  bus.m_real, er);
        chk({tag, "_imag"},  bus.m_imag, ei);
        tick();
        chk({tag, "_drop"},  bus.m_valid, 0);
        chk({tag, "_hold"},  bus.m_real, er);
    endtask

    // Write channels 0..31 (except skip); returns in the cycle after the last write.
    task automatic burst(input int skip);
        for (int ch = 0; ch < 32; ch++) begin
            if (ch != skip) begin
                bus.coef_dv   = 1'b1;
                bus.coef_chan = 5'(ch);
                bus.coef_real = 16'(cr_tab[ch]);
                bus.coef_imag = 16'(ci_tab[ch]);
                tick();
            end
        end
        bus.coef_dv = 1'b0;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        reset = 1'b1;
        bus.coef_dv = 1'b0; bus.coef_chan = '0; bus.coef_real = '0; bus.coef_imag = '0;
        bus.s_valid = 1'b0; bus.s_chan = '0; bus.s_real = '0; bus.s_imag = '0;
        tick();
        tick();
        reset = 1'b0;
        chk("rst_m_valid", bus.m_valid, 0);
        chk("rst_bank_valid", bus.bank_valid, 0);
        chk("rst_coef_err", bus.coef_err, 0);
        chk("rst_frame_cnt", bus.frame_cnt, 0);
        chk("rst_m_chan", bus.m_chan, 0);
        chk("rst_m_real", bus.m_real, 0);
        chk("rst_m_imag", bus.m_imag, 0);

        // No bank yet: coefficient is zero but the sample still comes out.
        send_sample("t6_nobank", 2, 1000, 1000, 0, 0);

        // T1: unity-half coefficients everywhere.
        for (int i = 0; i < 32; i++) begin cr_tab[i] = 16384; ci_tab[i] = 0; end
        burst(-1);
        chk("t1_bank_valid", bus.bank_valid, 1);
        chk("t1_frame_cnt", bus.frame_cnt, 1);
        chk("t1_coef_err", bus.coef_err, 0);
        tick();
        send_sample("t1", 5, 16384, 0, 8192, 0);

        // T2: purely imaginary, then 45-degree coefficient.
        cr_tab[7] = 0; ci_tab[7] = 16384;
        burst(-1);
        chk("t2_frame_cnt", bus.frame_cnt, 2);
        tick();
        send_sample("t2a", 7, 0, 16384, -8192, 0);
        cr_tab[7] = 23170; ci_tab[7] = 23170;
        burst(-1);
        tick();
        send_sample("t2b", 7, 10000, 0, 7071, 7071);

        // T3: saturation corners.
        cr_tab[9] = -32768; ci_tab[9] = 0;
        burst(-1);
        chk("t3_frame_cnt", bus.frame_cnt, 4);
        tick();
        send_sample("t3_sat", 9, -32768, 0, 32767, 0);
        send_sample("t3_neg", 9, 32767, 0, -32767, 0);

        // T5: burst missing channel 12 is rejected; old bank stays in use.
        for (int i = 0; i < 32; i++) begin cr_tab[i] = 0; ci_tab[i] = 0; end
        burst(12);
        chk("t5_coef_err", bus.coef_err, 1);
        chk("t5_frame_cnt", bus.frame_cnt, 4);
        chk("t5_bank_valid", bus.bank_valid, 1);
        tick();
        chk("t5_err_pulse", bus.coef_err, 0);
        send_sample("t5_old9", 9, 32767, 0, -32767, 0);
        send_sample("t5_old5", 5, 16384, 0, 8192, 0);

        // T4: continuous samples on ch 3 across a bank swap.
        for (int i = 0; i < 32; i++) begin cr_tab[i] = i * 256; ci_tab[i] = 0; end
        burst(-1);
        chk("t4_frame_a", bus.frame_cnt, 5);
        bus.s_valid = 1'b1; bus.s_chan = 5'd3; bus.s_real = 16'sd16384; bus.s_imag = 16'sd0;
        repeat (268) tick();
        chk("t4_steady_valid", bus.m_valid, 1);
        chk("t4_steady_real", bus.m_real, 384);
        for (int i = 0; i < 32; i++) cr_tab[i] = i * 512;
        burst(-1);
        chk("t4_frame_b", bus.frame_cnt, 6);
        repeat (3) tick();
        chk("t4_last_old", bus.m_real, 384);
        tick();
        chk("t4_first_new", bus.m_real, 768);
        chk("t4_chan", bus.m_chan, 3);
        bus.s_valid = 1'b0;
        repeat (5) tick();

        // Reset mid-burst with two samples in flight.
        for (int ch = 0; ch < 10; ch++) begin
            bus.coef_dv = 1'b1; bus.coef_chan = 5'(ch);
            bus.coef_real = 16'sd1000; bus.coef_imag = 16'sd0;
            bus.s_valid = (ch >= 8); bus.s_chan = 5'd4;
            bus.s_real = 16'sd1000; bus.s_imag = 16'sd0;
            tick();
        end
        bus.coef_dv = 1'b0; bus.s_valid = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rst2_bank_valid", bus.bank_valid, 0);
        chk("rst2_frame_cnt", bus.frame_cnt, 0);
        for (int k = 0; k < 4; k++) begin
            chk("rst2_no_valid", bus.m_valid, 0);
            tick();
        end

        // Partial burst before reset is gone: upper half alone is incomplete.
        for (int ch = 16; ch < 32; ch++) begin
            bus.coef_dv = 1'b1; bus.coef_chan = 5'(ch);
            bus.coef_real = 16'sd1000; bus.coef_imag = 16'sd0;
            tick();
        end
        bus.coef_dv = 1'b0;
        chk("rst2_discard_err", bus.coef_err, 1);
        chk("rst2_discard_bank", bus.bank_valid, 0);
        tick();
        send_sample("rst2_zero", 4, 1000, 1000, 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
